// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch-state encoding, instruction constants and
// small address helpers used by the fetch stage.
package cpu_pkg;

   // Fetch-stage FSM encoding
   typedef enum logic [1:0] {
      FS_BOOT   = 2'd0,
      FS_RUN    = 2'd1,
      FS_HALTED = 2'd2
   } fetch_state_e;

   // All-zero word is the architectural nop used for pipeline bubbles
   localparam logic [31:0] NOP_INST   = 32'h0000_0000;
   localparam int unsigned INST_BYTES = 32'd4;

   // Force a byte address onto a word boundary
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

   // Increment that sticks at all-ones instead of wrapping
   function automatic logic [31:0] sat_inc(input logic [31:0] val);
      logic [31:0] res;
      if (val == 32'hFFFF_FFFF) begin
         res = val;
      end else begin
         res = val + 32'd1;
      end
      return res;
   endfunction

endpackage : cpu_pkg

// File: rtl/ifid_reg.sv
// IF/ID pipeline latch. Flush loads a bubble (nop, invalid, pc4 kept),
// load captures a fetched instruction, otherwise the contents hold.
module ifid_reg
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        i_load,
   input  logic        i_flush,
   input  logic [31:0] i_inst,
   input  logic [31:0] i_pc4,
   output logic [31:0] o_inst,
   output logic [31:0] o_pc4,
   output logic        o_valid
);

   logic [31:0] r_inst;
   logic [31:0] r_pc4;
   logic        r_valid;

   // Latch update: flush wins over load; neither means hold (stall)
   always_ff @(posedge clk) begin
      if (reset) begin
         r_inst  <= NOP_INST;
         r_pc4   <= 32'h0000_0000;
         r_valid <= 1'b0;
      end else if (i_flush) begin
         r_inst  <= NOP_INST;
         r_pc4   <= r_pc4;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_inst  <= i_inst;
         r_pc4   <= i_pc4;
         r_valid <= 1'b1;
      end else begin
         r_inst  <= r_inst;
         r_pc4   <= r_pc4;
         r_valid <= r_valid;
      end
   end

   assign o_inst  = r_inst;
   assign o_pc4   = r_pc4;
   assign o_valid = r_valid;

endmodule : ifid_reg

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the combinational instruction
// memory and feeds the IF/ID latch. Handles stalls, taken-branch redirects
// and stops fetching once the PC leaves the program image.
// Optional feature macro: FETCH_PERF_CNT_EN adds fetch/stall counters.
module inst_fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_WORDS = 32'd16
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_inst,
   output logic [31:0] ifid_inst,
   output logic [31:0] ifid_pc4,
   output logic        ifid_valid,
   output logic        halted
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] fetch_cnt,
   output logic [31:0] stall_cnt
`endif
);

   // First byte address past the program image
   localparam logic [31:0] C_FETCH_LIMIT = 32'(IMEM_WORDS * INST_BYTES);

   fetch_state_e r_state;
   fetch_state_e w_state_nxt;
   logic [31:0]  r_pc;
   logic [31:0]  w_pc_nxt;
   logic [31:0]  w_pc_plus4;
   logic         r_halted;
   logic         w_load;
   logic         w_flush;
   logic         w_stall_cycle;

   assign w_pc_plus4 = r_pc + 32'(INST_BYTES);

   // Next-state, next-PC and IF/ID control decode
   always_comb begin
      w_state_nxt   = r_state;
      w_pc_nxt      = r_pc;
      w_load        = 1'b0;
      w_flush       = 1'b0;
      w_stall_cycle = 1'b0;
      case (r_state)
         FS_BOOT: begin
            // One bubble cycle before the first fetch; PC stays put
            w_flush     = 1'b1;
            w_state_nxt = FS_RUN;
         end
         FS_RUN: begin
            w_stall_cycle = stall & ~br_taken;
            if (br_taken) begin
               // Redirect overrides stall and squashes the fetch in flight
               w_pc_nxt = word_align(br_target);
               w_flush  = 1'b1;
            end else if (r_pc >= C_FETCH_LIMIT) begin
               // Ran off the image: stop fetching, PC parks where it is
               w_flush     = 1'b1;
               w_state_nxt = FS_HALTED;
            end else if (stall) begin
               w_pc_nxt = r_pc;
            end else begin
               w_load   = 1'b1;
               w_pc_nxt = w_pc_plus4;
            end
         end
         FS_HALTED: begin
            // Only a branch can restart fetch; stall is irrelevant here
            w_flush = 1'b1;
            if (br_taken) begin
               w_pc_nxt    = word_align(br_target);
               w_state_nxt = FS_RUN;
            end else begin
               w_pc_nxt = r_pc;
            end
         end
         default: begin
            w_flush     = 1'b1;
            w_state_nxt = FS_BOOT;
         end
      endcase
   end

   // State, PC and halted-flag registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= FS_BOOT;
         r_pc     <= RESET_PC;
         r_halted <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_pc     <= w_pc_nxt;
         r_halted <= (w_state_nxt == FS_HALTED);
      end
   end

   ifid_reg u_ifid_reg (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_load),
      .i_flush (w_flush),
      .i_inst  (imem_inst),
      .i_pc4   (w_pc_plus4),
      .o_inst  (ifid_inst),
      .o_pc4   (ifid_pc4),
      .o_valid (ifid_valid)
   );

   assign imem_addr = r_pc;
   assign halted    = r_halted;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_fetch_cnt;
   logic [31:0] r_stall_cnt;

   // Saturating counters of real fetches and stalled RUN cycles
   always_ff @(posedge clk) begin
      if (reset) begin
         r_fetch_cnt <= 32'h0000_0000;
         r_stall_cnt <= 32'h0000_0000;
      end else begin
         r_fetch_cnt <= w_load        ? sat_inc(r_fetch_cnt) : r_fetch_cnt;
         r_stall_cnt <= w_stall_cycle ? sat_inc(r_stall_cnt) : r_stall_cnt;
      end
   end

   assign fetch_cnt = r_fetch_cnt;
   assign stall_cnt = r_stall_cnt;
`else
   // Stall qualifier only feeds the optional counters
   logic w_unused_stall;
   assign w_unused_stall = w_stall_cycle;
`endif

endmodule : inst_fetch_unit

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: the stimulus process pushes the
// expected IF/ID contents for every cycle a valid instruction should be
// present; a negedge monitor pops and compares whenever ifid_valid is high.
module tb_inst_fetch_unit;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        br_taken;
   logic [31:0] br_target;
   logic [31:0] imem_addr;
   logic [31:0] imem_inst;
   logic [31:0] ifid_inst;
   logic [31:0] ifid_pc4;
   logic        ifid_valid;
   logic        halted;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt;
   logic [31:0] stall_cnt;
`endif

   int total;
   int bad;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc4;
   } exp_t;
   exp_t exp_q[$];

   inst_fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_WORDS(32'd16)) dut (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .br_taken   (br_taken),
      .br_target  (br_target),
      .imem_addr  (imem_addr),
      .imem_inst  (imem_inst),
      .ifid_inst  (ifid_inst),
      .ifid_pc4   (ifid_pc4),
      .ifid_valid (ifid_valid),
      .halted     (halted)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_cnt  (fetch_cnt),
      .stall_cnt  (stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Program image word at index i
   function automatic logic [31:0] mem_word(input int idx);
      return 32'hC0DE_0000 + 32'(idx * 17);
   endfunction

   // Combinational instruction memory; out-of-image reads return garbage
   always_comb begin
      if (imem_addr < 32'd64) begin
         imem_inst = mem_word(int'(imem_addr[5:2]));
      end else begin
         imem_inst = 32'hDEAD_BEEF ^ imem_addr;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Expect the word at index idx to be sitting in IF/ID after the next edge
   task automatic push_exp(input int idx);
      exp_t e;
      e.inst = mem_word(idx);
      e.pc4  = 32'((idx + 1) * 4);
      exp_q.push_back(e);
   endtask

   // Set inputs, then advance one edge and settle
   task automatic step(input logic s, input logic b, input logic [31:0] tgt);
      stall     = s;
      br_taken  = b;
      br_target = tgt;
      @(posedge clk);
      #1;
   endtask

   // Monitor: every valid IF/ID observation consumes one expectation
   always @(negedge clk) begin
      if (ifid_valid === 1'b1) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL ifid_unexpected: got inst=%h pc4=%h expected no valid", ifid_inst, ifid_pc4);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (ifid_inst !== e.inst || ifid_pc4 !== e.pc4) begin
               bad++;
               $display("FAIL ifid_data: got inst=%h pc4=%h expected inst=%h pc4=%h",
                        ifid_inst, ifid_pc4, e.inst, e.pc4);
            end
         end
      end
   end

   initial begin
      total     = 0;
      bad       = 0;
      reset     = 1'b1;
      stall     = 1'b0;
      br_taken  = 1'b0;
      br_target = 32'h0;

      // 1. Reset for two edges, then boot and fetch 0x0,0x4,0x8
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst_addr",   imem_addr, 32'h0);
      chk("rst_valid",  {31'd0, ifid_valid}, 32'd0);
      chk("rst_inst",   ifid_inst, 32'h0);
      chk("rst_pc4",    ifid_pc4, 32'h0);
      chk("rst_halted", {31'd0, halted}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
      chk("rst_fetch_cnt", fetch_cnt, 32'h0);
      chk("rst_stall_cnt", stall_cnt, 32'h0);
`endif
      reset = 1'b0;
      step(1'b0, 1'b0, 32'h0);           // BOOT bubble
      chk("boot_addr",  imem_addr, 32'h0);
      chk("boot_valid", {31'd0, ifid_valid}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         push_exp(i);
         step(1'b0, 1'b0, 32'h0);
      end
      chk("run_addr", imem_addr, 32'hC);

      // 2. Stall two cycles at PC=0xC: IF/ID keeps inst@0x8
      push_exp(2);
      step(1'b1, 1'b0, 32'h0);
      chk("stall1_addr", imem_addr, 32'hC);
      push_exp(2);
      step(1'b1, 1'b0, 32'h0);
      chk("stall2_addr", imem_addr, 32'hC);
      push_exp(3);
      step(1'b0, 1'b0, 32'h0);
      chk("resume_addr", imem_addr, 32'h10);

      // 3. Branch with stall in the same cycle, misaligned target
      step(1'b1, 1'b1, 32'h0000_003A);
      chk("br_addr",  imem_addr, 32'h38);
      chk("br_valid", {31'd0, ifid_valid}, 32'd0);
      push_exp(14);
      step(1'b0, 1'b0, 32'h0);
      push_exp(15);
      step(1'b0, 1'b0, 32'h0);
      chk("eoi_addr",      imem_addr, 32'h40);
      chk("eoi_halted_lo", {31'd0, halted}, 32'd0);

      // 4. End of image: halt, PC parks at 0x40, stall ignored
      step(1'b0, 1'b0, 32'h0);
      chk("halt_valid", {31'd0, ifid_valid}, 32'd0);
      chk("halt_flag",  {31'd0, halted}, 32'd1);
      chk("halt_addr",  imem_addr, 32'h40);
      step(1'b1, 1'b0, 32'h0);
      chk("halt_hold_flag", {31'd0, halted}, 32'd1);
      chk("halt_hold_addr", imem_addr, 32'h40);

      // 5. Leave halt via branch to 0x0
      step(1'b0, 1'b1, 32'h0);
      chk("unhalt_flag",  {31'd0, halted}, 32'd0);
      chk("unhalt_addr",  imem_addr, 32'h0);
      chk("unhalt_valid", {31'd0, ifid_valid}, 32'd0);
      for (int i = 0; i < 9; i++) begin
         push_exp(i);
         step(1'b0, 1'b0, 32'h0);
      end
      chk("pre_rst_addr", imem_addr, 32'h24);

      // 6. Mid-run reset with stall pending
      reset = 1'b1;
      step(1'b1, 1'b0, 32'h0);
      chk("mrst_addr",   imem_addr, 32'h0);
      chk("mrst_valid",  {31'd0, ifid_valid}, 32'd0);
      chk("mrst_pc4",    ifid_pc4, 32'h0);
      chk("mrst_halted", {31'd0, halted}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
      chk("mrst_fetch_cnt", fetch_cnt, 32'h0);
      chk("mrst_stall_cnt", stall_cnt, 32'h0);
`endif
      reset = 1'b0;
      step(1'b0, 1'b0, 32'h0);           // BOOT again
      chk("reboot_addr",  imem_addr, 32'h0);
      chk("reboot_valid", {31'd0, ifid_valid}, 32'd0);
      push_exp(0);
      step(1'b0, 1'b0, 32'h0);
      chk("refetch_addr", imem_addr, 32'h4);

      // Let the monitor drain, then every expectation must be consumed
      @(negedge clk);
      #1;
      chk("scoreboard_left", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_inst_fetch_unit
